// File: rtl/vram_host_writer.sv
// -----------------------------------------------------------------------------
// vram_host_writer
//
// Queues byte-wide host writes and drains them onto the shared 16-bit VRAM bus
// as word writes with byte enables. The bus is shared with VGA scan-out through
// an external arbiter, so the writer requests the bus and writes only while
// vram_gnt is held. It issues one word per granted cycle, in strict push order.
//
// Ports:
//   clock          sole clock, all state on the rising edge
//   reset          asynchronous, active-low reset
//   host_addr      byte address; bit 0 selects the byte lane
//   host_data      write byte
//   host_wr_valid  host write request
//   host_wr_ready  queue can accept (held low while reset is asserted)
//   vram_gnt       arbiter grant of the VRAM bus
//   vram_req       bus request (registered)
//   vram_we        write strobe, one word per asserted cycle (combinational)
//   vram_addr      word address of the queue head
//   vram_wdata     write data, the byte replicated on both lanes
//   vram_be        byte enables, bit0 = [7:0], bit1 = [15:8]; 00 when idle
//   fifo_count     number of queued entries
//
// Build option:
//   VRAM_WR_COALESCE_EN  When defined, a low-lane head entry that is followed
//                        by the high-lane entry of the same word is merged into
//                        a single be=11 write, and both entries pop together.
// -----------------------------------------------------------------------------
module vram_host_writer #(
  parameter int VRAM_DATA_WIDTH = 16,
  parameter int VRAM_ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [VRAM_ADDR_WIDTH:0]     host_addr,
  input  logic [7:0]                   host_data,
  input  logic                         host_wr_valid,
  output logic                         host_wr_ready,
  input  logic                         vram_gnt,
  output logic                         vram_req,
  output logic                         vram_we,
  output logic [VRAM_ADDR_WIDTH-1:0]   vram_addr,
  output logic [VRAM_DATA_WIDTH-1:0]   vram_wdata,
  output logic [1:0]                   vram_be,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            vram_req_reg;
  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [CW-1:0]   pop_cnt;
  logic            push;

  // Queue storage: no reset needed, validity is tracked by the pointers.
  logic [VRAM_ADDR_WIDTH:0] addr_mem [FIFO_DEPTH];
  logic [7:0]               data_mem [FIFO_DEPTH];

  logic [VRAM_ADDR_WIDTH:0] head_addr;
  logic [7:0]               head_data;

  // Gating ready with reset keeps the host from pushing while reset is held.
  assign host_wr_ready = reset && (count_reg != CW'(FIFO_DEPTH));
  assign push          = host_wr_valid && host_wr_ready;
  assign fifo_count    = count_reg;
  assign vram_req      = vram_req_reg;
  assign vram_we       = (state_reg == WRITE) && vram_gnt;

  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= host_addr;
      data_mem[wr_ptr_reg] <= host_data;
    end
  end

`ifdef VRAM_WR_COALESCE_EN
  logic [PW-1:0]            nxt_ptr;
  logic [VRAM_ADDR_WIDTH:0] nxt_addr;
  logic [7:0]               nxt_data;
  logic                     pair_ok;

  assign nxt_ptr  = rd_ptr_reg + PW'(1);
  assign nxt_addr = addr_mem[nxt_ptr];
  assign nxt_data = data_mem[nxt_ptr];
  // Merge only a low-lane head with the high lane of the same word directly
  // behind it; any other ordering stays as separate writes to keep push order.
  assign pair_ok  = (count_reg >= CW'(2)) && !head_addr[0] && nxt_addr[0] &&
                    (nxt_addr[VRAM_ADDR_WIDTH:1] == head_addr[VRAM_ADDR_WIDTH:1]);
`endif

  // Bus presentation and pop amount for the current cycle.
  always_comb begin
    vram_addr  = head_addr[VRAM_ADDR_WIDTH:1];
    vram_wdata = {head_data, head_data};
    vram_be    = 2'b00;
    pop_cnt    = '0;
    if (vram_we) begin
`ifdef VRAM_WR_COALESCE_EN
      if (pair_ok) begin
        vram_be    = 2'b11;
        vram_wdata = {nxt_data, head_data};
        pop_cnt    = CW'(2);
      end else begin
        vram_be    = head_addr[0] ? 2'b10 : 2'b01;
        pop_cnt    = CW'(1);
      end
`else
      vram_be    = head_addr[0] ? 2'b10 : 2'b01;
      pop_cnt    = CW'(1);
`endif
    end
  end

  assign count_next = count_reg + CW'(push) - pop_cnt;

  // Next state. count_next includes same-cycle pushes, so a host streaming
  // in during WRITE keeps the burst going while the grant holds.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = REQ;
      REQ:     if (vram_gnt) state_next = WRITE;
      WRITE: begin
        if (!vram_gnt)              state_next = REQ;
        else if (count_next == '0)  state_next = IDLE;
        else                        state_next = WRITE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      vram_req_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      vram_req_reg <= (state_next != IDLE);
      count_reg    <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      // Power-of-two depth: the pointer truncation is the modulo wrap.
      rd_ptr_reg   <= rd_ptr_reg + pop_cnt[PW-1:0];
    end
  end

endmodule
